// File: rtl/array_seq_ctrl_if.sv
// Command, array-control and result-stream signals of the systolic array sequencer.
// The abort input exists only when ARRAY_SEQ_CTRL_ABORT_EN is defined.
interface array_seq_ctrl_if #(
    parameter int unsigned SIZE = 4,
    parameter int unsigned K_W  = 8
);
    localparam int unsigned KI_W = K_W + $clog2(SIZE) + 1;

    logic                   start;
    logic [K_W-1:0]         k_len;
    logic                   busy;
    logic                   done;
    logic                   load_en;
    logic                   mult_en;
    logic                   acc_en;
    logic [KI_W-1:0]        k_idx;
    logic [SIZE-1:0]        lane_valid;
    logic [SIZE*SIZE-1:0]   select;
    logic [31:0]            d_in;
    logic [31:0]            out_data;
    logic                   out_valid;
    logic                   out_ready;

`ifdef ARRAY_SEQ_CTRL_ABORT_EN
    logic                   abort;

    modport master (
        input  start, k_len, abort, d_in, out_ready,
        output busy, done, load_en, mult_en, acc_en, k_idx, lane_valid, select,
               out_data, out_valid
    );
    modport slave (
        output start, k_len, abort, d_in, out_ready,
        input  busy, done, load_en, mult_en, acc_en, k_idx, lane_valid, select,
               out_data, out_valid
    );
`else
    modport master (
        input  start, k_len, d_in, out_ready,
        output busy, done, load_en, mult_en, acc_en, k_idx, lane_valid, select,
               out_data, out_valid
    );
    modport slave (
        output start, k_len, d_in, out_ready,
        input  busy, done, load_en, mult_en, acc_en, k_idx, lane_valid, select,
               out_data, out_valid
    );
`endif
endinterface

// File: rtl/array_seq_ctrl.sv
// Sequencer for a SIZE x SIZE systolic MAC array: clear, skewed feed, drain, result readout.
// Define ARRAY_SEQ_CTRL_ABORT_EN to add an abort input that returns the sequencer to idle.
module array_seq_ctrl #(
    parameter int unsigned SIZE    = 4,
    parameter int unsigned K_W     = 8,
    parameter int unsigned MAC_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    array_seq_ctrl_if.master bus
);
    localparam int unsigned KI_W  = K_W + $clog2(SIZE) + 1;
    localparam int unsigned SEL_W = SIZE * SIZE;
    localparam int unsigned DL_W  = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StDrain,
        StRead,
        StDone
    } state_e;

    state_e            r_state;
    logic [K_W-1:0]    r_klen;
    logic [DL_W-1:0]   r_dcnt;
    logic              r_busy;
    logic              r_done;
    logic              r_load_en;
    logic              r_mult_en;
    logic              r_acc_en;
    logic              r_out_valid;
    logic [KI_W-1:0]   r_k_idx;
    logic [SIZE-1:0]   r_lane;
    logic [SEL_W-1:0]  r_sel;

    logic [KI_W-1:0]   w_k_last;
    logic [KI_W-1:0]   w_k_next;
    logic [SIZE-1:0]   w_lane_next;
    logic              w_abort;

`ifdef ARRAY_SEQ_CTRL_ABORT_EN
    assign w_abort = bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    // Feed runs k_len+2*SIZE-2 cycles; the skew makes row r live on t in [r, r+k_len).
    assign w_k_last = KI_W'(r_klen) + KI_W'(2 * SIZE - 2) - KI_W'(1);
    assign w_k_next = (r_state == StClear) ? '0 : r_k_idx + KI_W'(1);

    always_comb begin
        w_lane_next = '0;
        for (int r = 0; r < SIZE; r++) begin
            w_lane_next[r] = (w_k_next >= KI_W'(r)) && (w_k_next < KI_W'(r) + KI_W'(r_klen));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_klen      <= '0;
            r_dcnt      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_load_en   <= 1'b0;
            r_mult_en   <= 1'b0;
            r_acc_en    <= 1'b0;
            r_out_valid <= 1'b0;
            r_k_idx     <= '0;
            r_lane      <= '0;
            r_sel       <= '0;
        end else if (w_abort && (r_state != StIdle)) begin
            r_state     <= StIdle;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_load_en   <= 1'b0;
            r_mult_en   <= 1'b0;
            r_acc_en    <= 1'b0;
            r_out_valid <= 1'b0;
            r_lane      <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_klen    <= bus.k_len;
                        r_state   <= StClear;
                        r_busy    <= 1'b1;
                        r_load_en <= 1'b1;
                        r_k_idx   <= '0;
                    end
                end
                StClear: begin
                    r_load_en <= 1'b0;
                    r_acc_en  <= 1'b1;
                    r_dcnt    <= '0;
                    if (r_klen == '0) begin
                        r_state <= StDrain;
                    end else begin
                        r_state   <= StFeed;
                        r_mult_en <= 1'b1;
                        r_k_idx   <= w_k_next;
                        r_lane    <= w_lane_next;
                    end
                end
                StFeed: begin
                    if (r_k_idx == w_k_last) begin
                        r_state   <= StDrain;
                        r_mult_en <= 1'b0;
                        r_lane    <= '0;
                    end else begin
                        r_k_idx <= w_k_next;
                        r_lane  <= w_lane_next;
                    end
                end
                StDrain: begin
                    if (r_dcnt == DL_W'(MAC_LAT - 1)) begin
                        r_state     <= StRead;
                        r_acc_en    <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_sel       <= '0;
                    end else begin
                        r_dcnt <= r_dcnt + DL_W'(1);
                    end
                end
                StRead: begin
                    if (bus.out_ready) begin
                        if (r_sel == SEL_W'(SEL_W - 1)) begin
                            r_state     <= StDone;
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_sel <= r_sel + SEL_W'(1);
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.load_en    = r_load_en;
    assign bus.mult_en    = r_mult_en;
    assign bus.acc_en     = r_acc_en;
    assign bus.k_idx      = r_k_idx;
    assign bus.lane_valid = r_lane;
    assign bus.select     = r_sel;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = bus.d_in;
endmodule

// File: tb/tb_array_seq_ctrl.sv
// Scoreboard bench for array_seq_ctrl: a counting array stub supplies d_in, results and timing
// are predicted from closed-form arithmetic at each start and checked by a separate monitor.
module tb_array_seq_ctrl;
    localparam int unsigned SIZE    = 4;
    localparam int unsigned K_W     = 8;
    localparam int unsigned MAC_LAT = 2;
    localparam int unsigned NRES    = SIZE * SIZE;

    logic clk = 1'b0;
    logic reset;

    array_seq_ctrl_if #(.SIZE(SIZE), .K_W(K_W)) bus ();

    array_seq_ctrl #(.SIZE(SIZE), .K_W(K_W), .MAC_LAT(MAC_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    typedef struct {
        int unsigned p;
        int unsigned k;
    } seq_t;
    typedef struct {
        logic [15:0] sel;
        logic [31:0] data;
    } exp_t;

    seq_t q_seq[$];
    exp_t q_exp[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail(input string name);
        nvec++;
        nerr++;
        $display("FAIL %s: got event, expected none (cycle %0d)", name, cyc);
    endtask

    // Cell (i,j) sees k_len-|i-j| overlapping live cycles of row i and column j.
    function automatic int unsigned model_cell(input int unsigned k, input int i, input int j);
        int d;
        d = (i > j) ? i - j : j - i;
        return (k > d) ? k - d : 0;
    endfunction

    function automatic int unsigned feed_len(input int unsigned k);
        return (k == 0) ? 0 : k + 2 * SIZE - 2;
    endfunction

    function automatic logic [SIZE-1:0] lanes(input int unsigned t, input int unsigned k);
        logic [SIZE-1:0] v;
        for (int r = 0; r < SIZE; r++) v[r] = (t >= r) && (t < r + k);
        return v;
    endfunction

    // Array stub: each cell counts mult_en cycles where its row and column are both live.
    int unsigned cell_cnt[NRES];
    logic [15:0] salt = 16'h0;

    always @(posedge clk) begin
        if (bus.load_en) begin
            for (int n = 0; n < NRES; n++) cell_cnt[n] <= 0;
        end else if (bus.mult_en) begin
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                    if (bus.lane_valid[i] && bus.lane_valid[j]) begin
                        cell_cnt[i*SIZE+j] <= cell_cnt[i*SIZE+j] + 1;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.d_in = 32'hDEAD_BEEF;
        if (bus.select < NRES) bus.d_in = {salt, 16'(cell_cnt[int'(bus.select)])};
    end

    // Monitor state.
    seq_t        cur;
    bit          cur_act    = 0;
    bit          first_seen = 0;
    bit          prev_hold  = 0;
    bit          prev_done  = 0;
    bit          prev_load  = 0;
    logic [15:0] prev_sel   = '0;
    int unsigned mult_cnt   = 0;
    int unsigned hs_cnt     = 0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            cur_act   = 0;
            prev_hold = 0;
            prev_done = 0;
            prev_load = 0;
        end else begin
            if (prev_hold) begin
                chk("hold_out_valid", bus.out_valid, 1);
                chk("hold_select", bus.select, prev_sel);
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_sel  = bus.select;
            if (bus.load_en) begin
                chk("load_en_width", prev_load, 0);
                if (q_seq.size() == 0) begin
                    fail("unexpected_sequence");
                end else begin
                    cur        = q_seq.pop_front();
                    cur_act    = 1;
                    first_seen = 0;
                    mult_cnt   = 0;
                    hs_cnt     = 0;
                    chk("clear_cycle", cyc, cur.p);
                end
            end
            prev_load = bus.load_en;
            if (bus.mult_en) begin
                if (!cur_act) begin
                    fail("mult_en_outside_sequence");
                end else begin
                    chk("k_idx", bus.k_idx, cyc - cur.p - 1);
                    chk("lane_valid", bus.lane_valid, lanes(cyc - cur.p - 1, cur.k));
                    chk("acc_en_with_mult", bus.acc_en, 1);
                    mult_cnt++;
                end
            end
            if (bus.out_valid && cur_act && !first_seen) begin
                first_seen = 1;
                chk("first_valid_latency", cyc - (cur.p - 1), 2 + feed_len(cur.k) + MAC_LAT);
                chk("mult_en_cycles", mult_cnt, feed_len(cur.k));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q_exp.size() == 0) begin
                    fail("extra_result");
                end else begin
                    e = q_exp.pop_front();
                    chk("select", bus.select, e.sel);
                    chk("out_data", bus.out_data, e.data);
                    hs_cnt++;
                end
            end
            if (bus.done) begin
                chk("done_width", prev_done, 0);
                if (cur_act) begin
                    chk("handshakes", hs_cnt, NRES);
                    chk("busy_in_done", bus.busy, 1);
                    cur_act = 0;
                end else begin
                    fail("spurious_done");
                end
            end
            prev_done = bus.done;
        end
    end

    // out_ready driver: 0 = always ready, 1 = random, 2 = left to the test sequence.
    int ready_mode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) bus.out_ready = ($urandom_range(0, 3) != 0);
            else if (ready_mode == 0) bus.out_ready = 1'b1;
        end
    end

    task automatic push_results(input int unsigned k);
        exp_t e;
        for (int n = 0; n < NRES; n++) begin
            e.sel  = 16'(n);
            e.data = {salt, 16'(model_cell(k, n / SIZE, n % SIZE))};
            q_exp.push_back(e);
        end
    endtask

    task automatic issue(input int unsigned k);
        seq_t s;
        salt       = 16'($urandom);
        bus.start  = 1'b1;
        bus.k_len  = K_W'(k);
        s.p        = cyc + 1;
        s.k        = k;
        q_seq.push_back(s);
        push_results(k);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.k_len = K_W'($urandom);
    endtask

    task automatic wait_done(input int unsigned bound);
        int unsigned n = 0;
        while (bus.done !== 1'b1 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= bound) fail("done_timeout");
        @(posedge clk);
        #1;
        chk("idle_after_done", bus.busy, 0);
    endtask

    task automatic wait_sel(input int unsigned sel, input int unsigned bound);
        int unsigned n = 0;
        while (!(bus.out_valid === 1'b1 && bus.select == sel) && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= bound) fail("select_timeout");
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_load_en"}, bus.load_en, 0);
        chk({tag, "_mult_en"}, bus.mult_en, 0);
        chk({tag, "_acc_en"}, bus.acc_en, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_lane_valid"}, bus.lane_valid, 0);
        chk({tag, "_k_idx"}, bus.k_idx, 0);
        chk({tag, "_select"}, bus.select, 0);
    endtask

    task automatic flush_model();
        q_seq.delete();
        q_exp.delete();
        cur_act   = 0;
        prev_hold = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected $finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned p0;
        int unsigned per;
        int unsigned k;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.k_len     = '0;
        bus.out_ready = 1'b1;
`ifdef ARRAY_SEQ_CTRL_ABORT_EN
        bus.abort     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic run, always ready.
        issue(4);
        wait_done(200);

        // Backpressure: hold ready low for 3 cycles at select 5.
        ready_mode    = 2;
        bus.out_ready = 1'b1;
        issue(3);
        wait_sel(5, 200);
        bus.out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("bp_select_held", bus.select, 5);
        chk("bp_valid_held", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        wait_done(200);
        ready_mode = 0;

        // Empty inner dimension: results are the cleared accumulators.
        issue(0);
        wait_done(200);

        // start held high: back-to-back sequences, each beginning right after DONE.
        k         = 2;
        per       = feed_len(k) + MAC_LAT + NRES + 3;
        salt      = 16'($urandom);
        bus.start = 1'b1;
        bus.k_len = K_W'(k);
        p0        = cyc + 1;
        for (int s = 0; s < 3; s++) begin
            q_seq.push_back('{p: p0 + s * per, k: k});
            push_results(k);
        end
        while (cyc < p0 + 2 * per) begin
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        wait_done(400);
        repeat (30) @(posedge clk);
        #1;

        // Reset in the middle of FEED at k_idx 3.
        issue(5);
        p0 = cyc;
        while (cyc < p0 + 4) begin
            @(posedge clk);
            #1;
        end
        chk("k_idx_before_reset", bus.k_idx, 3);
        reset = 1'b1;
        flush_model();
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_reset_outputs("midrun_reset");
        issue(4);
        wait_done(200);

`ifdef ARRAY_SEQ_CTRL_ABORT_EN
        // Abort during READ at select 7, then a clean run; start wins over abort in idle.
        ready_mode    = 2;
        bus.out_ready = 1'b1;
        issue(3);
        wait_sel(7, 200);
        bus.out_ready = 1'b0;
        bus.abort     = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        flush_model();
        chk("abort_busy", bus.busy, 0);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_acc_en", bus.acc_en, 0);
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", bus.done, 0);
        end
        ready_mode = 0;
        bus.abort  = 1'b1;
        issue(1);
        bus.abort  = 1'b0;
        wait_done(200);
`endif

        // Randomized runs with random backpressure and ignored starts while busy.
        ready_mode = 1;
        for (int it = 0; it < 8; it++) begin
            k = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
            issue(k);
            repeat ($urandom_range(1, 4)) begin
                @(posedge clk);
                #1;
            end
            bus.start = 1'b1;
            bus.k_len = K_W'($urandom);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            wait_done(3000);
        end

        ready_mode = 0;
        repeat (20) @(posedge clk);
        #1;
        chk("results_left", q_exp.size(), 0);
        chk("sequences_left", q_seq.size(), 0);
        chk("final_busy", bus.busy, 0);
        chk("final_out_valid", bus.out_valid, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
